uart_tx_serializer: RTL and testbench

//  UART transmitter: the transmit end of the team's 8N1 serial link, paired with the receiver.

---
 rtl/uart_tx_serializer.sv | 136 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: valid/ready byte in, start + 8 data LSB-first + stop out.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] TC = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_serializer: illegal parameter value");
    end

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        done_n;
    logic        tc;

    assign tc       = (cnt == TC);
    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_bit = (^shift_n) ^ (PARITY_ODD != 0);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        shift_n = shift;
        done_n  = 1'b0;
        tx_n    = 1'b1;

        case (state)
            IDLE: begin
                cnt_n = 16'd0;
                idx_n = 3'd0;
                if (tx_valid) begin
                    shift_n = tx_data;
                    state_n = START;
                end
            end
            START: begin
                if (tc) begin
                    cnt_n   = 16'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tc) begin
                    cnt_n = 16'd0;
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tc) begin
                    cnt_n   = 16'd0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tc) begin
                    cnt_n   = 16'd0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                cnt_n   = 16'd0;
                idx_n   = 3'd0;
                state_n = IDLE;
            end
        endcase

        // tx is registered, so it is driven from the state being entered
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[idx_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_bit;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            idx     <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            tx_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at CLKS_PER_BIT=4 and =1.
// Expected line levels come from a frame-level model of the serial format.
module tb_uart_tx_serializer;

    localparam int C0 = 4;
    localparam int C1 = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int PODD = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       v0, v1;
    logic       tx0, rdy0, busy0, done0;
    logic       tx1, rdy1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(C0), .PARITY_ODD(PODD)) u0 (
        .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(tx_data),
        .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(C1), .PARITY_ODD(PODD)) u1 (
        .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(tx_data),
        .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input int sel, input logic v);
        if (sel == 1) v1 = v;
        else          v0 = v;
    endtask

    // Send one frame starting at a negedge where the DUT is idle; ends
    // at the negedge of the tx_done cycle with the next request applied.
    task automatic run_frame(input int sel, input logic [7:0] d,
                             input bit b2b, input logic [7:0] nd);
        int         c, len, b;
        logic       eb [NB];
        logic [7:0] rx;
        logic       t, r, bz, dn;
        c  = (sel == 1) ? C1 : C0;
        len = NB * c;
        rx = 8'h00;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        eb[9] = (^d) ^ 1'(PODD);
`endif
        eb[NB-1] = 1'b1;
        chk("ready_before", (sel == 1) ? rdy1 : rdy0, 1'b1);
        set_valid(sel, 1'b1);
        tx_data = d;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            t  = (sel == 1) ? tx1   : tx0;
            r  = (sel == 1) ? rdy1  : rdy0;
            bz = (sel == 1) ? busy1 : busy0;
            dn = (sel == 1) ? done1 : done0;
            if (k <= len) begin
                b = (k - 1) / c;
                chk($sformatf("tx_bit%0d", b), t, eb[b]);
                chk("ready_busy", r, 1'b0);
                chk("busy", bz, 1'b1);
                chk("done_early", dn, 1'b0);
                if ((k - 1) % c == c / 2 && b >= 1 && b <= 8)
                    rx[b-1] = t;
                set_valid(sel, 1'($urandom));
                tx_data = 8'($urandom);
            end else begin
                chk("done_pulse", dn, 1'b1);
                chk("ready_done", r, 1'b1);
                chk("busy_done", bz, 1'b0);
                chk("tx_idle", t, 1'b1);
                chk("rx_byte", rx, d);
                set_valid(sel, b2b);
                tx_data = b2b ? nd : 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] cur, nxt;
        bit         bb;
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        tx_data = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", tx0, 1'b1);
            chk("rst_ready", rdy0, 1'b1);
            chk("rst_busy", busy0, 1'b0);
            chk("rst_done", done0, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", tx0, 1'b1);
        chk("post_rst_ready", rdy0, 1'b1);

        run_frame(0, 8'hA5, 1'b0, 8'h00);
        @(negedge clk);
        chk("done_one_cycle", done0, 1'b0);

        run_frame(0, 8'h00, 1'b1, 8'hFF);
        run_frame(0, 8'hFF, 1'b0, 8'h00);

        run_frame(0, 8'h3C, 1'b0, 8'h00);

        // Abort 0x55 in data bit 3, with a byte offered during reset
        v0 = 1'b1;
        tx_data = 8'h55;
        for (int k = 1; k <= 4 * C0 + 2; k++) begin
            @(negedge clk);
            v0 = 1'b0;
        end
        chk("abort_bit3", tx0, 1'b0);
        rst = 1'b1;
        v0 = 1'b1;
        tx_data = 8'h81;
        @(negedge clk);
        chk("abort_tx", tx0, 1'b1);
        chk("abort_ready", rdy0, 1'b1);
        chk("abort_done", done0, 1'b0);
        @(negedge clk);
        chk("rst_blocks_valid", rdy0, 1'b1);
        rst = 1'b0;
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", done0, 1'b0);
            chk("abort_idle_tx", tx0, 1'b1);
        end
        run_frame(0, 8'h81, 1'b0, 8'h00);

        cur = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            nxt = 8'($urandom);
            bb  = 1'($urandom);
            run_frame(0, cur, bb, nxt);
            cur = nxt;
        end
        v0 = 1'b0;

        @(negedge clk);
        cur = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            nxt = 8'($urandom);
            bb  = (i < 3);
            run_frame(1, cur, bb, nxt);
            cur = nxt;
        end
        v1 = 1'b0;
        @(negedge clk);
        chk("c1_idle_tx", tx1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
